// File: rtl/md_seq.sv
// Iterative 32-bit multiply/divide sequencer that owns the HI/LO registers.
// Optional MD_SEQ_EARLY_TERM_EN: multiplies stop early once the remaining multiplier bits are zero.
module md_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic        cancel,
  input  logic [1:0]  hilo_we,
  input  logic [31:0] hilo_wdata,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_CALC, S_FIX} state_t;

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        div_zero_q, div_zero_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] wlo_q, wlo_d;
  logic [31:0] opnd_q, opnd_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;

  logic        is_signed, neg_a, neg_b;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [33:0] div_diff;
  logic [63:0] prod;
`ifdef MD_SEQ_EARLY_TERM_EN
  logic [31:0] rem_mask;
`endif

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    op_d       = op_q;
    dvd_d      = dvd_q;
    acc_d      = acc_q;
    wlo_d      = wlo_q;
    opnd_d     = opnd_q;
    cnt_d      = cnt_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;

    is_signed = ~op_q[0];
    neg_a     = is_signed & wlo_q[31];
    neg_b     = is_signed & opnd_q[31];
    mul_sum   = {1'b0, acc_q} + {1'b0, opnd_q};
    div_shift = {acc_q, wlo_q[31]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
    prod      = {acc_q, wlo_q};
`ifdef MD_SEQ_EARLY_TERM_EN
    rem_mask  = (32'd1 << cnt_q) - 32'd1;
    // An early exit leaves the product shifted up by the unconsumed step count.
    if (!op_q[1]) prod = prod >> cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (hilo_we[1]) hi_d = hilo_wdata;
        if (hilo_we[0]) lo_d = hilo_wdata;
        if (start && !cancel) begin
          state_d    = S_PREP;
          busy_d     = 1'b1;
          div_zero_d = 1'b0;
          op_d       = md_op;
          dvd_d      = data1;
          wlo_d      = data1;
          opnd_d     = data2;
        end
      end
      S_PREP: begin
        wlo_d     = neg_a ? -wlo_q : wlo_q;
        opnd_d    = neg_b ? -opnd_q : opnd_q;
        acc_d     = '0;
        neg_res_d = neg_a ^ neg_b;
        neg_rem_d = neg_a;
        cnt_d     = 5'd31;
        state_d   = S_CALC;
      end
      S_CALC: begin
        if (op_q[1]) begin
          // Restoring step: keep the subtraction only when it did not borrow.
          acc_d = div_diff[33] ? div_shift[31:0] : div_diff[31:0];
          wlo_d = {wlo_q[30:0], ~div_diff[33]};
        end else if (wlo_q[0]) begin
          {acc_d, wlo_d} = {mul_sum, wlo_q[31:1]};
        end else begin
          {acc_d, wlo_d} = {1'b0, acc_q, wlo_q[31:1]};
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          state_d = S_FIX;
          cnt_d   = 5'd0;
        end
`ifdef MD_SEQ_EARLY_TERM_EN
        if (!op_q[1] && ((wlo_q[31:1] & rem_mask[30:0]) == 31'd0)) begin
          state_d = S_FIX;
          cnt_d   = cnt_q;
        end
`endif
      end
      S_FIX: begin
        if (op_q[1]) begin
          if (opnd_q == 32'd0) begin
            lo_d       = 32'hFFFF_FFFF;
            hi_d       = dvd_q;
            div_zero_d = 1'b1;
          end else begin
            lo_d = neg_res_q ? -wlo_q : wlo_q;
            hi_d = neg_rem_q ? -acc_q : acc_q;
          end
        end else begin
          {hi_d, lo_d} = neg_res_q ? -prod : prod;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // A flush abandons the op without touching the architectural registers.
    if (cancel && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      hi_d       = hi_q;
      lo_d       = lo_q;
      div_zero_d = div_zero_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      op_q       <= '0;
      dvd_q      <= '0;
      acc_q      <= '0;
      wlo_q      <= '0;
      opnd_q     <= '0;
      cnt_q      <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      op_q       <= op_d;
      dvd_q      <= dvd_d;
      acc_q      <= acc_d;
      wlo_q      <= wlo_d;
      opnd_q     <= opnd_d;
      cnt_q      <= cnt_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
